fifo_uart_tx_drain: RTL and testbench

- Single-clock UART transmitter that drains the read port of the team's async circular FIFO.
- Sits directly downstream of the FIFO, in the read clock domain.
- Pops one word whenever the FIFO is non-empty and the line is idle, then serializes it: start bit, LSB-first data, optional even parity, stop bit(s).
- Handshake is one-cycle pop strobes, so the FIFO's read pointer advances exactly once per transmitted frame.

---
 rtl/fifo_uart_tx_drain.sv | 133 +++++++++++++
 tb/tb_fifo_uart_tx_drain.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_drain.sv
// UART transmitter that pops words from a show-ahead FIFO read port and sends
// them as start / LSB-first data / optional even parity / stop-bit frames.
module fifo_uart_tx_drain #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             nrst_in,
  input  logic             enable_in,
  input  logic             empty_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             read_out,
  output logic             tx_out,
  output logic             busy_out,
  output logic             frame_done_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cyc_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_q;
  logic             read_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             slot_end;

  assign slot_end = (cyc_q == CW'(CLKS_PER_BIT - 1));

  // NOTE: every register here is state, so all updates are non-blocking; the
  // pulse outputs get a default of 0 so they only live for one cycle.
  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      read_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      read_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        cyc_q <= slot_end ? '0 : cyc_q + CW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (enable_in && !empty_in) begin
            shift_q <= data_in;
            par_q   <= ^data_in;
            read_q  <= 1'b1;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            cyc_q   <= '0;
            bit_q   <= '0;
            state_q <= S_START;
          end else begin
            tx_q <= 1'b1;
          end
        end
        S_START: begin
          if (slot_end) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= BW'(1);
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          // bit_q counts data bits already placed on the line.
          if (slot_end) begin
            if (bit_q == BW'(WIDTH)) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (slot_end) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (slot_end) begin
            if (bit_q == BW'(STOP_BITS - 1)) begin
              bit_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_out       = read_q;
  assign tx_out         = tx_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: a queue-based FIFO model feeds two instances
// (no parity / even parity); a line decoder checks frames against a scoreboard.
module tb_fifo_uart_tx_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sel = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_head = 8'h00;
  logic       en0, en1;
  logic       rd0, tx0, busy0, done0;
  logic       rd1, tx1, busy1, done1;
  logic       rd_s, tx_s, busy_s, done_s;

  int         checks = 0;
  int         errors = 0;
  int         cyc_cnt = 0;
  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  int         rd_cyc[$];
  int         done_cyc[$];
  int         busy_cnt = 0;
  int         frames_seen = 0;
  logic       prev_rd = 1'b0;
  logic [10:0] last_slots = '1;

  logic        in_frame = 1'b0;
  int          mcnt = 0;
  logic [10:0] slots = '1;

  assign en0    = en & ~sel;
  assign en1    = en & sel;
  assign rd_s   = sel ? rd1 : rd0;
  assign tx_s   = sel ? tx1 : tx0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;

  fifo_uart_tx_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .nrst_in(rst_n), .enable_in(en0), .empty_in(fifo_empty), .data_in(fifo_head),
    .read_out(rd0), .tx_out(tx0), .busy_out(busy0), .frame_done_out(done0)
  );

  fifo_uart_tx_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .nrst_in(rst_n), .enable_in(en1), .empty_in(fifo_empty), .data_in(fifo_head),
    .read_out(rd1), .tx_out(tx1), .busy_out(busy1), .frame_done_out(done1)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    fifo_empty = (fifo.size() == 0);
    fifo_head  = fifo_empty ? 8'h00 : fifo[0];
  endtask

  task automatic push(input logic [7:0] v);
    fifo.push_back(v);
    exp_q.push_back(v);
    refresh();
  endtask

  task automatic clear_stats();
    rd_cyc.delete();
    done_cyc.delete();
    busy_cnt = 0;
  endtask

  // FIFO read side and cycle bookkeeping; sees pre-edge DUT outputs.
  always @(posedge clk) begin
    cyc_cnt++;
    if (busy_s === 1'b1) busy_cnt++;
    if (done_s === 1'b1) done_cyc.push_back(cyc_cnt);
    if (rd_s === 1'b1) begin
      rd_cyc.push_back(cyc_cnt);
      checks++;
      if (tx_s !== 1'b0 || prev_rd || fifo.size() == 0) begin
        errors++;
        $display("FAIL pop_strobe: tx=%b prev_rd=%b fifo_size=%0d, required tx=0 prev_rd=0 size>0",
                 tx_s, prev_rd, fifo.size());
      end
      if (fifo.size() != 0) fifo.delete(0);
      refresh();
    end
    prev_rd = rd_s;
  end

  // Line decoder: samples each bit slot one cycle after its start edge.
  always @(negedge clk) begin
    int k;
    int nslots;
    logic [7:0] data;
    logic [7:0] expv;
    nslots = sel ? 11 : 10;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_s === 1'b0) begin
        in_frame = 1'b1;
        mcnt     = 0;
        slots    = '1;
      end
    end else begin
      mcnt++;
      if (mcnt % CPB == 1) begin
        k = mcnt / CPB;
        slots[k] = tx_s;
        if (k == nslots - 1) begin
          data = slots[8:1];
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got data=%h, required no frame", data);
          end else begin
            expv = exp_q.pop_front();
            if (data !== expv || slots[0] !== 1'b0 || slots[nslots-1] !== 1'b1 ||
                (sel && slots[9] !== ^expv)) begin
              errors++;
              $display("FAIL frame: got data=%h slots=%b, required data=%h start=0 stop=1",
                       data, slots, expv);
            end
          end
          last_slots  = slots;
          frames_seen++;
          in_frame    = 1'b0;
        end
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_seen < target) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d frames, required %0d", frames_seen, target);
    end
  endtask

  task automatic wait_reads(input int target, input int budget);
    int n = 0;
    while (rd_cyc.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rd_cyc.size() < target) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got %0d pops, required %0d", rd_cyc.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, rd0, busy0, done0} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dut0: got tx/rd/busy/done=%b, required 1000", {tx0, rd0, busy0, done0});
    end
    checks++;
    if ({tx1, rd1, busy1, done1} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dut1: got tx/rd/busy/done=%b, required 1000", {tx1, rd1, busy1, done1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int f0;
    sel = 1'b0;
    en  = 1'b0;
    clear_stats();
    f0 = frames_seen;
    push(8'hA5);
    en = 1'b1;
    wait_frames(f0 + 1, 200);
    repeat (8) @(negedge clk);
    checks++;
    if (rd_cyc.size() != 1) begin
      errors++;
      $display("FAIL single_pops: got %0d, required 1", rd_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || rd_cyc.size() < 1 || done_cyc[0] - rd_cyc[0] != 40) begin
      errors++;
      $display("FAIL single_done: got %0d pulses (first at +%0d), required 1 at +40",
               done_cyc.size(),
               (done_cyc.size() > 0 && rd_cyc.size() > 0) ? done_cyc[0] - rd_cyc[0] : -1);
    end
    checks++;
    if (busy_cnt != 40) begin
      errors++;
      $display("FAIL single_busy: got %0d cycles, required 40", busy_cnt);
    end
    checks++;
    if (last_slots[9:0] !== 10'b11_0100_1010) begin
      errors++;
      $display("FAIL single_slots: got %b, required 1101001010", last_slots[9:0]);
    end
  endtask

  task automatic test_empty();
    int bad = 0;
    sel = 1'b0;
    en  = 1'b1;
    clear_stats();
    repeat (100) begin
      @(negedge clk);
      if (tx_s !== 1'b1 || busy_s !== 1'b0) bad++;
    end
    checks++;
    if (rd_cyc.size() != 0) begin
      errors++;
      $display("FAIL empty_pops: got %0d, required 0", rd_cyc.size());
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL empty_line: got %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    sel = 1'b0;
    en  = 1'b0;
    clear_stats();
    f0 = frames_seen;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    en = 1'b1;
    wait_frames(f0 + 3, 400);
    repeat (8) @(negedge clk);
    checks++;
    if (rd_cyc.size() != 3 || rd_cyc[1] - rd_cyc[0] != 41 || rd_cyc[2] - rd_cyc[1] != 41) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d pops spacing %0d/%0d, required 3 pops spacing 41/41",
               rd_cyc.size(), rd_cyc.size() > 1 ? rd_cyc[1] - rd_cyc[0] : -1,
               rd_cyc.size() > 2 ? rd_cyc[2] - rd_cyc[1] : -1);
    end
    checks++;
    if (done_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses, required 3", done_cyc.size());
    end
    checks++;
    if (fifo.size() != 0 || tx_s !== 1'b1 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got fifo=%0d tx=%b busy=%b, required 0 1 0", fifo.size(), tx_s, busy_s);
    end
  endtask

  task automatic test_parity();
    int f0;
    en  = 1'b0;
    sel = 1'b1;
    clear_stats();
    f0 = frames_seen;
    push(8'hA5);
    en = 1'b1;
    wait_frames(f0 + 1, 200);
    repeat (8) @(negedge clk);
    checks++;
    if (last_slots[9] !== 1'b0) begin
      errors++;
      $display("FAIL parity_a5: got %b, required 0", last_slots[9]);
    end
    checks++;
    if (done_cyc.size() != 1 || rd_cyc.size() != 1 || done_cyc[0] - rd_cyc[0] != 44) begin
      errors++;
      $display("FAIL parity_len: got %0d, required 44",
               (done_cyc.size() > 0 && rd_cyc.size() > 0) ? done_cyc[0] - rd_cyc[0] : -1);
    end
    clear_stats();
    push(8'h07);
    wait_frames(f0 + 2, 200);
    repeat (8) @(negedge clk);
    checks++;
    if (last_slots[9] !== 1'b1) begin
      errors++;
      $display("FAIL parity_07: got %b, required 1", last_slots[9]);
    end
    en  = 1'b0;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int f0;
    int r;
    int c;
    sel = 1'b0;
    en  = 1'b0;
    clear_stats();
    push(8'h3C);
    push(8'h5A);
    en = 1'b1;
    wait_reads(1, 20);
    r = (rd_cyc.size() > 0) ? rd_cyc[0] : cyc_cnt;
    while (cyc_cnt < r + 14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got tx=%b busy=%b rd=%b, required 1 0 0", tx0, busy0, rd0);
    end
    if (exp_q.size() != 0) exp_q.delete(0);
    checks++;
    if (fifo.size() != 1 || fifo[0] !== 8'h5A) begin
      errors++;
      $display("FAIL reset_fifo: got size=%0d, required 1 word 5a", fifo.size());
    end
    f0 = frames_seen;
    repeat (3) @(negedge clk);
    clear_stats();
    rst_n = 1'b1;
    c = cyc_cnt;
    wait_frames(f0 + 1, 200);
    repeat (8) @(negedge clk);
    checks++;
    if (rd_cyc.size() != 1 || rd_cyc[0] != c + 2) begin
      errors++;
      $display("FAIL reset_restart: got %0d pops first at %0d, required 1 at %0d",
               rd_cyc.size(), rd_cyc.size() > 0 ? rd_cyc[0] : -1, c + 2);
    end
    checks++;
    if (fifo.size() != 0) begin
      errors++;
      $display("FAIL reset_dup: got fifo size %0d, required 0", fifo.size());
    end
  endtask

  task automatic test_enable_drop();
    int f0;
    sel = 1'b0;
    en  = 1'b0;
    clear_stats();
    f0 = frames_seen;
    push(8'h11);
    push(8'h22);
    en = 1'b1;
    wait_reads(1, 20);
    while (rd_cyc.size() > 0 && cyc_cnt < rd_cyc[0] + 9) @(negedge clk);
    en = 1'b0;
    wait_frames(f0 + 1, 200);
    repeat (60) @(negedge clk);
    checks++;
    if (rd_cyc.size() != 1 || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL endrop_hold: got pops=%0d done=%0d, required 1 1", rd_cyc.size(), done_cyc.size());
    end
    checks++;
    if (fifo.size() != 1) begin
      errors++;
      $display("FAIL endrop_fifo: got size %0d, required 1", fifo.size());
    end
    en = 1'b1;
    wait_frames(f0 + 2, 200);
    repeat (8) @(negedge clk);
    checks++;
    if (rd_cyc.size() != 2) begin
      errors++;
      $display("FAIL endrop_resume: got %0d pops, required 2", rd_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    test_enable_drop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d undelivered words, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
